// File: rtl/uart_cmd_parser.sv
// ASCII read-command parser: "R" + 6 hex address digits + 2 hex length digits + CR/LF.
// It decodes the command into an {addr, len} request on a valid/ready handshake, with error pulses and an inter-byte timeout.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT = 27_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_read,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [23:0] cmd_addr,
   output logic [8:0]  cmd_len,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
   localparam bit TMO_EN = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      TERM,
      OUT,
      SKIP
   } state_e;

   typedef enum logic [1:0] {
      ERR_TIMEOUT = 2'd0,
      ERR_HEX     = 2'd1,
      ERR_TERM    = 2'd2,
      ERR_CMD     = 2'd3
   } err_e;

   state_e        state_q, state_nx;
   logic [2:0]    dcnt_q, dcnt_nx;
   logic [23:0]   addr_q, addr_nx;
   logic [7:0]    len_q, len_nx;
   logic [23:0]   cmd_addr_q, cmd_addr_nx;
   logic [8:0]    cmd_len_q, cmd_len_nx;
   logic          err_q, err_nx;
   err_e          err_code_q, err_code_nx;
   logic [TW-1:0] tmo_q, tmo_nx;

   logic consume;
   logic counting;
   logic tmo_hit;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) ||
             (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   // Letters share the low nibble 1..6 in both cases, so A..F / a..f map to low nibble + 9.
   function automatic logic [3:0] hex_nib(input logic [7:0] b);
      return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
   endfunction

   function automatic logic is_eol(input logic [7:0] b);
      return (b == 8'h0D) || (b == 8'h0A);
   endfunction

   assign rx_read   = rx_valid && !rst && (state_q != OUT);
   assign consume   = rx_valid && rx_read;
   assign cmd_valid = (state_q == OUT);
   assign cmd_addr  = cmd_addr_q;
   assign cmd_len   = cmd_len_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

   assign counting = (state_q == ADDR) || (state_q == LEN) ||
                     (state_q == TERM) || (state_q == SKIP);
   // A consumed byte always beats an expiring counter.
   assign tmo_hit  = TMO_EN && counting && !consume && (tmo_q == TMO_LIMIT);

   always_comb begin
      // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and infers a latch.
      state_nx    = state_q;
      dcnt_nx     = dcnt_q;
      addr_nx     = addr_q;
      len_nx      = len_q;
      cmd_addr_nx = cmd_addr_q;
      cmd_len_nx  = cmd_len_q;
      err_nx      = 1'b0;
      err_code_nx = err_code_q;
      tmo_nx      = tmo_q;

      if (consume) begin
         tmo_nx = '0;
      end else if (TMO_EN && counting && !tmo_hit) begin
         tmo_nx = tmo_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (consume) begin
               if (rx_data == 8'h52 || rx_data == 8'h72) begin
                  state_nx = ADDR;
                  addr_nx  = '0;
                  dcnt_nx  = '0;
               end else if (!(is_eol(rx_data) || rx_data == 8'h20)) begin
                  state_nx    = SKIP;
                  err_nx      = 1'b1;
                  err_code_nx = ERR_CMD;
               end
            end
         end

         ADDR: begin
            if (consume) begin
               if (is_hex(rx_data)) begin
                  addr_nx = {addr_q[19:0], hex_nib(rx_data)};
                  if (dcnt_q == 3'd5) begin
                     state_nx = LEN;
                     dcnt_nx  = '0;
                  end else begin
                     dcnt_nx = dcnt_q + 3'd1;
                  end
               end else begin
                  state_nx    = SKIP;
                  err_nx      = 1'b1;
                  err_code_nx = ERR_HEX;
               end
            end else if (tmo_hit) begin
               state_nx    = IDLE;
               err_nx      = 1'b1;
               err_code_nx = ERR_TIMEOUT;
            end
         end

         LEN: begin
            if (consume) begin
               if (is_hex(rx_data)) begin
                  len_nx = {len_q[3:0], hex_nib(rx_data)};
                  if (dcnt_q == 3'd1) begin
                     state_nx = TERM;
                  end else begin
                     dcnt_nx = dcnt_q + 3'd1;
                  end
               end else begin
                  state_nx    = SKIP;
                  err_nx      = 1'b1;
                  err_code_nx = ERR_HEX;
               end
            end else if (tmo_hit) begin
               state_nx    = IDLE;
               err_nx      = 1'b1;
               err_code_nx = ERR_TIMEOUT;
            end
         end

         TERM: begin
            if (consume) begin
               if (is_eol(rx_data)) begin
                  state_nx    = OUT;
                  cmd_addr_nx = addr_q;
                  cmd_len_nx  = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
               end else begin
                  state_nx    = SKIP;
                  err_nx      = 1'b1;
                  err_code_nx = ERR_TERM;
               end
            end else if (tmo_hit) begin
               state_nx    = IDLE;
               err_nx      = 1'b1;
               err_code_nx = ERR_TIMEOUT;
            end
         end

         SKIP: begin
            if (consume) begin
               if (is_eol(rx_data)) begin
                  state_nx = IDLE;
               end
            end else if (tmo_hit) begin
               state_nx    = IDLE;
               err_nx      = 1'b1;
               err_code_nx = ERR_TIMEOUT;
            end
         end

         OUT: begin
            if (cmd_ready) begin
               state_nx = IDLE;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is written with non-blocking assignments so every register samples the pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         dcnt_q     <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         cmd_addr_q <= '0;
         cmd_len_q  <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_TIMEOUT;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_nx;
         dcnt_q     <= dcnt_nx;
         addr_q     <= addr_nx;
         len_q      <= len_nx;
         cmd_addr_q <= cmd_addr_nx;
         cmd_len_q  <= cmd_len_nx;
         err_q      <= err_nx;
         err_code_q <= err_code_nx;
         tmo_q      <= tmo_nx;
      end
   end

endmodule
